// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the data memory / MMIO block.
package mmio_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_IDX_W  = 5;

  // I/O register indices (addr[6:2] inside the I/O window)
  localparam int unsigned OUT_BASE   = 0;
  localparam int unsigned IN_BASE    = 8;
  localparam int unsigned STATUS_IDX = 16;
  localparam int unsigned CYCLE_IDX  = 17;

  typedef logic [WORD_W-1:0] word_t;

  // Replace the byte lanes of old_word selected by be with those of new_word
  function automatic word_t merge_be(input word_t old_word, input word_t new_word,
                                     input logic [3:0] be);
    word_t res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_in_sync.sv
// One input port: synchroniser chain, previous-value register and sticky change flag.
module mmio_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_async,
  input  logic        clr,
  output logic [31:0] synced,
  output logic        changed
);

  logic [31:0] stage_q [SYNC_STAGES];
  logic [31:0] stage_d [SYNC_STAGES];
  logic [31:0] prev_q, prev_d;
  logic        changed_q, changed_d;

  // Shift the chain, remember last synced value, set-dominant change flag
  always_comb begin
    stage_d[0] = in_async;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    prev_d    = stage_q[SYNC_STAGES-1];
    changed_d = (stage_q[SYNC_STAGES-1] != prev_q) | (changed_q & ~clr);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
    end
  end

  assign synced  = stage_q[SYNC_STAGES-1];
  assign changed = changed_q;

endmodule

// File: rtl/sc_datamem_mmio.sv
// Data memory with memory-mapped I/O window for the single-cycle CPU.
module sc_datamem_mmio
  import mmio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 5,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned IO_SEL_BIT  = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           datain,
  input  logic                  we,
  input  logic [3:0]            be,
  output logic [31:0]           dataout,
  output logic [31:0]           mem_dataout,
  output logic [31:0]           io_read_data,
  output logic [NUM_OUT*32-1:0] out_port,
  input  logic [NUM_IN*32-1:0]  in_port,
  output logic [NUM_IN-1:0]     in_changed
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic                  ram_sel, io_sel, io_wr;
  logic [REG_IDX_W-1:0]  reg_idx;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  unused_addr;

  logic [31:0]       ram [DEPTH];
  logic [31:0]       out_q [NUM_OUT];
  logic [31:0]       out_d [NUM_OUT];
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       in_synced [NUM_IN];
  logic [NUM_IN-1:0] in_chg;
  logic [NUM_IN-1:0] w1c_clr;

  assign io_sel      = addr[IO_SEL_BIT];
  assign ram_sel     = ~addr[IO_SEL_BIT];
  assign reg_idx     = addr[6:2];
  assign word_idx    = addr[DEPTH_LOG2+1:2];
  assign io_wr       = we & io_sel;
  assign unused_addr = ^addr;

  // RAM: per-byte write, no reset, blocked while reset is asserted
  always_ff @(posedge clock) begin
    if (!reset && we && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[word_idx][8*i +: 8] <= datain[8*i +: 8];
      end
    end
  end

  assign mem_dataout = ram[word_idx];

  // Status W1C bits all live in byte lane 0
  always_comb begin
    w1c_clr = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w1c_clr[k] = io_wr & (reg_idx == REG_IDX_W'(STATUS_IDX)) & be[0] & datain[k];
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < NUM_IN; gk++) begin : g_in
      mmio_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .in_async (in_port[32*gk +: 32]),
        .clr      (w1c_clr[gk]),
        .synced   (in_synced[gk]),
        .changed  (in_chg[gk])
      );
    end
  endgenerate

  // Next state for output registers and the cycle counter
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      out_d[k] = out_q[k];
      if (io_wr && (reg_idx == REG_IDX_W'(OUT_BASE + k))) begin
        out_d[k] = merge_be(out_q[k], datain, be);
      end
    end
    cycle_d = cycle_q + 32'd1;
    if (io_wr && (reg_idx == REG_IDX_W'(CYCLE_IDX)) && (be != 4'b0000)) begin
      cycle_d = merge_be(cycle_q, datain, be);
    end
  end

  // Register update; reset dominates any same-cycle write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        out_q[k] <= '0;
      end
      cycle_q <= '0;
    end else begin
      out_q   <= out_d;
      cycle_q <= cycle_d;
    end
  end

  // Combinational I/O read decode
  always_comb begin
    io_read_data = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (reg_idx == REG_IDX_W'(OUT_BASE + k)) io_read_data = out_q[k];
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (reg_idx == REG_IDX_W'(IN_BASE + k)) io_read_data = in_synced[k];
    end
    if (reg_idx == REG_IDX_W'(STATUS_IDX)) io_read_data = 32'(in_chg);
    if (reg_idx == REG_IDX_W'(CYCLE_IDX))  io_read_data = cycle_q;
  end

  assign dataout = io_sel ? io_read_data : mem_dataout;

  // Flatten output registers onto the port bus
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      out_port[32*k +: 32] = out_q[k];
    end
  end

  assign in_changed = in_chg;

endmodule
